tpu_seq_ctrl: RTL and testbench
===============================

Name: tpu_seq_ctrl

Overview:
- Host-facing command sequencer for the TPU datapath (memA, memB, systolic array).
- Decodes host read/write transactions into load/unload strobes and runs the matmul compute phase as a counted state machine.
- Back-pressures the host while the array is computing and reports completion through a sticky status bit and a one-cycle pulse.
- Instantiated in the TPU top level; drives the existing datapath control pins.

Parameters:
- DIM, 8, array dimension (rows/cols).
- ADDRW, 16, host address width.
- COMPUTE_CYCLES, 3*DIM-2, number of cycles the array, memA and memB are enabled per matmul.
- CNTW, $clog2(COMPUTE_CYCLES+1), compute counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller accepts command this cycle.
- cmd_rw  in  1  0=read, 1=write.
- cmd_addr  in  ADDRW  host address.
- memA_wren  out  1  write row of memA.
- memA_row  out  $clog2(DIM)  memA row index.
- memA_en  out  1  memA shift enable.
- memB_en  out  1  memB shift/load enable.
- sa_en  out  1  systolic array enable.
- sa_wren  out  1  write C row of array.
- sa_crow  out  $clog2(DIM)  C row index.
- c_half  out  1  C half select (0=cols 0..DIM/2-1, 1=upper).
- rsp_valid  out  1  read data valid (registered).
- rsp_src  out  2  read mux select: 0=C low, 1=C high, 2=status.
- busy  out  1  compute in progress.
- done_pulse  out  1  one-cycle pulse at compute end.
- done_sticky  out  1  completion flag, cleared by status read.
- err_pulse  out  1  illegal command accepted.

Behaviour:
- One clock clk; reset rst is asynchronous and active-high.
- Reset: state IDLE, counter 0; cmd_ready=1; all strobes/enables, rsp_valid, rsp_src, busy, done_pulse, done_sticky, err_pulse = 0. Reset mid-compute aborts immediately, with no done_pulse.
- FSM states:
  - IDLE: cmd_ready=1.
  - COMPUTE: cmd_ready=0, busy=1, memA_en=memB_en=sa_en=1.
  - DONE: one cycle, cmd_ready=0, done_pulse=1. Next state is IDLE.
- Accept = cmd_valid & cmd_ready. Decode is on cmd_addr[11:8]. Strobes are combinational in the accept cycle; the data path samples dataIn the same cycle.
  - 0x1, write: memA_wren=1, memA_row=cmd_addr[5:3].
  - 0x2, write: memB_en=1 (one B row shifted in).
  - 0x3, write: sa_wren=1, sa_crow=cmd_addr[6:4], c_half=cmd_addr[3].
  - 0x3, read: sa_crow=cmd_addr[6:4], c_half=cmd_addr[3]. Next cycle: rsp_valid=1, rsp_src=cmd_addr[3]. sa_crow and c_half hold their values through the response cycle.
  - 0x4, write: start. Load counter=COMPUTE_CYCLES, enter COMPUTE next edge.
  - 0x5, read: status. Next cycle: rsp_valid=1, rsp_src=2. done_sticky clears on that edge unless done_pulse is high in the same cycle; set wins.
  - Any other region, or wrong direction (read of 0x1/0x2/0x4, write of 0x5): accepted, err_pulse=1 for the accept cycle, no other side effect.
- Outputs not being driven default to 0.
- COMPUTE:
  - Counter decrements each cycle.
  - Transition to DONE when counter==1 is decremented. Enables are therefore high for exactly COMPUTE_CYCLES cycles, starting the cycle after start is accepted.
- DONE: done_pulse=1, done_sticky set on exit edge.
- Commands presented while cmd_ready=0 are not accepted. The host must hold cmd_valid and cmd_addr stable until accept.
- rsp_valid: exactly one cycle per accepted read, never for writes or errors.
- The start command is the only path into COMPUTE. Back-to-back start is possible from IDLE after DONE.

Test Plan:
- Reset then idle → all outputs 0, cmd_ready=1; assert rst mid-COMPUTE at cycle 5 → next cycle busy=0, sa_en=0, no done_pulse.
- Write addr 0x0118 → memA_wren=1, memA_row=3 in accept cycle only; write 0x0200 → memB_en=1 for one cycle.
- Start (write 0x0400) at cycle T with DIM=8 → sa_en/memA_en/memB_en high cycles T+1..T+22, cmd_ready=0 throughout, done_pulse at T+23, cmd_ready=1 at T+24.
- During COMPUTE hold cmd_valid with read 0x0338 → not accepted until IDLE. After accept: sa_crow=3, c_half=1, then rsp_valid=1 with rsp_src=1 next cycle.
- After compute, read 0x0500 → rsp_src=2, done_sticky clears. A second status read returns done_sticky=0.
- Read 0x0400 and write 0x0700 → err_pulse=1, no rsp_valid, no state change.

Source files
------------

// File: rtl/tpu_seq_ctrl_if.sv
// Host command bus and datapath control pins of the TPU sequencer.
// The host (master) drives the command fields; the sequencer (slave) drives everything else.
interface tpu_seq_ctrl_if #(
  parameter int DIM   = 8,
  parameter int ADDRW = 16
);
  localparam int RW = $clog2(DIM);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rw;
  logic [ADDRW-1:0] cmd_addr;

  logic             memA_wren;
  logic [RW-1:0]    memA_row;
  logic             memA_en;
  logic             memB_en;
  logic             sa_en;
  logic             sa_wren;
  logic [RW-1:0]    sa_crow;
  logic             c_half;

  logic             rsp_valid;
  logic [1:0]       rsp_src;
  logic             busy;
  logic             done_pulse;
  logic             done_sticky;
  logic             err_pulse;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr,
    input  cmd_ready,
    input  memA_wren, memA_row, memA_en, memB_en, sa_en, sa_wren, sa_crow, c_half,
    input  rsp_valid, rsp_src, busy, done_pulse, done_sticky, err_pulse
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr,
    output cmd_ready,
    output memA_wren, memA_row, memA_en, memB_en, sa_en, sa_wren, sa_crow, c_half,
    output rsp_valid, rsp_src, busy, done_pulse, done_sticky, err_pulse
  );
endinterface

// File: rtl/tpu_seq_ctrl.sv
// TPU command sequencer: decodes host accesses into datapath strobes and runs the
// counted matmul compute phase, reporting completion via pulse and sticky flag.
module tpu_seq_ctrl #(
  parameter int DIM            = 8,
  parameter int ADDRW          = 16,
  parameter int COMPUTE_CYCLES = 3*DIM-2,
  parameter int CNTW           = $clog2(COMPUTE_CYCLES+1)
) (
  input  logic          clk,
  input  logic          rst,
  tpu_seq_ctrl_if.slave bus
);

  localparam int RW = $clog2(DIM);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(COMPUTE_CYCLES);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  // Legal regions per direction: writes to 1..4, reads of 3 and 5.
  localparam logic [15:0] WR_OK_MASK = 16'h001E;
  localparam logic [15:0] RD_OK_MASK = 16'h0028;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            rsp_valid_reg;
  logic [1:0]      rsp_src_reg;
  logic [RW-1:0]   crow_reg;
  logic            half_reg;
  logic            sticky_reg, sticky_next;

  logic            cmd_ready_c;
  logic            accept;
  logic [15:0]     region_hit;
  logic            wr_ok, rd_ok;
  logic            wr_a, wr_b, wr_c, rd_c, start_cmd, rd_st, cmd_err;
  logic            busy_c, run_en, done_c;
  logic [RW-1:0]   addr_row_a;
  logic [RW-1:0]   addr_row_c;
  logic            addr_half;
  logic            unused_addr;

  // Command acceptance depends only on the registered state, never on the command.
  assign cmd_ready_c = (state_reg == S_IDLE);
  assign accept      = bus.cmd_valid & cmd_ready_c;

  for (genvar gi = 0; gi < 16; gi++) begin : g_region
    assign region_hit[gi] = (bus.cmd_addr[11:8] == 4'(gi));
  end

  assign wr_ok = |(region_hit & WR_OK_MASK);
  assign rd_ok = |(region_hit & RD_OK_MASK);

  assign wr_a      = accept &  bus.cmd_rw & region_hit[1];
  assign wr_b      = accept &  bus.cmd_rw & region_hit[2];
  assign wr_c      = accept &  bus.cmd_rw & region_hit[3];
  assign start_cmd = accept &  bus.cmd_rw & region_hit[4];
  assign rd_c      = accept & ~bus.cmd_rw & region_hit[3];
  assign rd_st     = accept & ~bus.cmd_rw & region_hit[5];
  assign cmd_err   = accept & ~(bus.cmd_rw ? wr_ok : rd_ok);

  assign addr_row_a = bus.cmd_addr[3 +: RW];
  assign addr_row_c = bus.cmd_addr[4 +: RW];
  assign addr_half  = bus.cmd_addr[3];
  assign unused_addr = ^{bus.cmd_addr[ADDRW-1:12], bus.cmd_addr[7], bus.cmd_addr[2:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_c     = 1'b0;
    run_en     = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start_cmd) begin
          state_next = S_COMPUTE;
          cnt_next   = CNT_LOAD;
        end
      end
      S_COMPUTE: begin
        busy_c   = 1'b1;
        run_en   = 1'b1;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_c     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // A completion arriving together with a status read keeps the flag set.
  always_comb begin
    sticky_next = sticky_reg;
    if (done_c) begin
      sticky_next = 1'b1;
    end else if (rd_st) begin
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_src_reg   <= 2'd0;
      crow_reg      <= '0;
      half_reg      <= 1'b0;
      sticky_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rsp_valid_reg <= rd_c | rd_st;
      rsp_src_reg   <= rd_st ? 2'd2 : (rd_c ? {1'b0, addr_half} : 2'd0);
      crow_reg      <= rd_c ? addr_row_c : '0;
      half_reg      <= rd_c & addr_half;
      sticky_reg    <= sticky_next;
    end
  end

  assign bus.cmd_ready   = cmd_ready_c;
  assign bus.memA_wren   = wr_a;
  assign bus.memA_row    = wr_a ? addr_row_a : '0;
  assign bus.memA_en     = run_en;
  assign bus.memB_en     = run_en | wr_b;
  assign bus.sa_en       = run_en;
  assign bus.sa_wren     = wr_c;
  // A new C access takes the row select; otherwise a pending C read keeps its row.
  assign bus.sa_crow     = (wr_c | rd_c) ? addr_row_c : crow_reg;
  assign bus.c_half      = (wr_c | rd_c) ? addr_half  : half_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_src     = rsp_src_reg;
  assign bus.busy        = busy_c;
  assign bus.done_pulse  = done_c;
  assign bus.done_sticky = sticky_reg;
  assign bus.err_pulse   = cmd_err;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Bench for tpu_seq_ctrl: cycle-timeline model checked every cycle plus directed
// literal expectations for strobes, compute length, responses and errors.
module tb_tpu_seq_ctrl;
  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int CC    = 3*DIM-2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   sa_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;

  tpu_seq_ctrl_if #(.DIM(DIM), .ADDRW(ADDRW)) bus();

  tpu_seq_ctrl #(.DIM(DIM), .ADDRW(ADDRW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.sa_en) sa_cnt <= sa_cnt + 1;
    if (bus.done_pulse) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic legal(input logic rw, input logic [3:0] rg);
    case (rg)
      4'd1, 4'd2, 4'd4: return rw;
      4'd3:             return 1'b1;
      4'd5:             return !rw;
      default:          return 1'b0;
    endcase
  endfunction

  // Timeline model: compute occupies the CC cycles after the start accept, then one done cycle.
  initial begin : model
    int          start_cyc;
    logic        sticky_m, prev_rd, prev_half;
    logic [1:0]  prev_src;
    logic [2:0]  prev_crow;
    logic        in_c, in_d, rdy, acc, rw, c_acc;
    logic [3:0]  rg;
    logic [15:0] a;
    start_cyc = -1; sticky_m = 0; prev_rd = 0; prev_half = 0; prev_src = 0; prev_crow = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        start_cyc = -1; sticky_m = 0; prev_rd = 0; prev_half = 0; prev_src = 0; prev_crow = 0;
      end
      a     = bus.cmd_addr;
      rw    = bus.cmd_rw;
      rg    = a[11:8];
      in_c  = (start_cyc >= 0) && (cyc > start_cyc) && (cyc <= start_cyc + CC);
      in_d  = (start_cyc >= 0) && (cyc == start_cyc + CC + 1);
      rdy   = !(in_c || in_d);
      acc   = bus.cmd_valid && rdy;
      c_acc = acc && (rg == 4'd3);
      chk("cmd_ready",   32'(bus.cmd_ready),   32'(rdy));
      chk("busy",        32'(bus.busy),        32'(in_c));
      chk("sa_en",       32'(bus.sa_en),       32'(in_c));
      chk("memA_en",     32'(bus.memA_en),     32'(in_c));
      chk("memB_en",     32'(bus.memB_en),     32'(in_c || (acc && rw && rg == 4'd2)));
      chk("memA_wren",   32'(bus.memA_wren),   32'(acc && rw && rg == 4'd1));
      chk("memA_row",    32'(bus.memA_row),    32'((acc && rw && rg == 4'd1) ? a[5:3] : 3'd0));
      chk("sa_wren",     32'(bus.sa_wren),     32'(acc && rw && rg == 4'd3));
      chk("sa_crow",     32'(bus.sa_crow),     32'(c_acc ? a[6:4] : prev_crow));
      chk("c_half",      32'(bus.c_half),      32'(c_acc ? a[3] : prev_half));
      chk("rsp_valid",   32'(bus.rsp_valid),   32'(prev_rd));
      chk("rsp_src",     32'(bus.rsp_src),     32'(prev_src));
      chk("done_pulse",  32'(bus.done_pulse),  32'(in_d));
      chk("done_sticky", 32'(bus.done_sticky), 32'(sticky_m));
      chk("err_pulse",   32'(bus.err_pulse),   32'(acc && !legal(rw, rg)));
      if (!rst) begin
        if (acc && rw && rg == 4'd4) start_cyc = cyc;
        if (in_d) sticky_m = 1'b1;
        else if (acc && !rw && rg == 4'd5) sticky_m = 1'b0;
        prev_rd   = acc && !rw && (rg == 4'd3 || rg == 4'd5);
        prev_src  = !prev_rd ? 2'd0 : ((rg == 4'd5) ? 2'd2 : {1'b0, a[3]});
        prev_crow = (acc && !rw && rg == 4'd3) ? a[6:4] : 3'd0;
        prev_half = acc && !rw && (rg == 4'd3) && a[3];
      end
    end
  end

  task automatic issue(input logic rw, input logic [15:0] addr, output int acc_cyc);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr %0h: cmd_ready got 0, expected 1 within 200 cycles", addr);
    end
    acc_cyc = cyc;
    #1;
  endtask

  task automatic idle_cmd();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    #1;
  endtask

  initial begin : stim
    int t, t_start, t_rd, t2, s0, d1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("lit_reset_ready",  32'(bus.cmd_ready),   32'd1);
    chk("lit_reset_sticky", 32'(bus.done_sticky), 32'd0);
    chk("lit_reset_busy",   32'(bus.busy),        32'd0);

    issue(1'b1, 16'h0118, t);
    chk("lit_memA_wren", 32'(bus.memA_wren), 32'd1);
    chk("lit_memA_row",  32'(bus.memA_row),  32'd3);
    idle_cmd();
    chk("lit_memA_wren_off", 32'(bus.memA_wren), 32'd0);

    issue(1'b1, 16'h0200, t);
    chk("lit_memB_en", 32'(bus.memB_en), 32'd1);
    idle_cmd();
    chk("lit_memB_en_off", 32'(bus.memB_en), 32'd0);

    issue(1'b1, 16'h0338, t);
    chk("lit_sa_wren",    32'(bus.sa_wren), 32'd1);
    chk("lit_sa_crow_wr", 32'(bus.sa_crow), 32'd3);
    idle_cmd();

    // Start, then hold a C read through the whole compute phase.
    s0 = sa_cnt;
    issue(1'b1, 16'h0400, t_start);
    issue(1'b0, 16'h0338, t_rd);
    chk("lit_start_to_accept", 32'(t_rd - t_start),    32'd24);
    chk("lit_sa_en_cycles",    32'(sa_cnt - s0),       32'd22);
    chk("lit_done_cycle",      32'(done_cyc - t_start), 32'd23);
    chk("lit_crow_accept",     32'(bus.sa_crow),       32'd3);
    chk("lit_half_accept",     32'(bus.c_half),        32'd1);
    chk("lit_rsp_not_yet",     32'(bus.rsp_valid),     32'd0);
    idle_cmd();
    chk("lit_rsp_valid_c",  32'(bus.rsp_valid), 32'd1);
    chk("lit_rsp_src_c",    32'(bus.rsp_src),   32'd1);
    chk("lit_crow_hold",    32'(bus.sa_crow),   32'd3);
    chk("lit_half_hold",    32'(bus.c_half),    32'd1);
    @(posedge clk); #2;
    chk("lit_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);

    issue(1'b0, 16'h0500, t);
    chk("lit_sticky_set", 32'(bus.done_sticky), 32'd1);
    idle_cmd();
    chk("lit_rsp_src_st",   32'(bus.rsp_src),     32'd2);
    chk("lit_sticky_clear", 32'(bus.done_sticky), 32'd0);
    issue(1'b0, 16'h0500, t);
    chk("lit_sticky_second", 32'(bus.done_sticky), 32'd0);
    idle_cmd();
    chk("lit_rsp_valid_st2", 32'(bus.rsp_valid), 32'd1);

    issue(1'b0, 16'h0400, t);
    chk("lit_err_rd_start", 32'(bus.err_pulse), 32'd1);
    idle_cmd();
    chk("lit_err_no_rsp",  32'(bus.rsp_valid), 32'd0);
    chk("lit_err_no_busy", 32'(bus.busy),      32'd0);
    issue(1'b1, 16'h0700, t);
    chk("lit_err_wr_0x7", 32'(bus.err_pulse), 32'd1);
    idle_cmd();
    chk("lit_err_no_rsp2", 32'(bus.rsp_valid), 32'd0);
    issue(1'b1, 16'h0500, t);
    idle_cmd();
    issue(1'b0, 16'h0100, t);
    idle_cmd();

    issue(1'b0, 16'h0350, t);
    chk("lit_crow_low", 32'(bus.sa_crow), 32'd5);
    idle_cmd();
    chk("lit_rsp_src_low", 32'(bus.rsp_src), 32'd0);

    // Back-to-back starts: the second waits for IDLE after DONE.
    issue(1'b1, 16'h0400, t);
    issue(1'b1, 16'h0400, t2);
    chk("lit_b2b_start", 32'(t2 - t), 32'd24);
    idle_cmd();
    repeat (30) @(posedge clk);
    #2;
    chk("lit_sticky_after_b2b", 32'(bus.done_sticky), 32'd1);

    // Reset five cycles into compute aborts without a done pulse.
    issue(1'b1, 16'h0400, t);
    idle_cmd();
    while (cyc < t + 5) begin
      @(posedge clk); #1;
    end
    d1 = done_cnt;
    rst = 1'b1;
    #1;
    chk("lit_rst_busy",   32'(bus.busy),        32'd0);
    chk("lit_rst_sa_en",  32'(bus.sa_en),       32'd0);
    chk("lit_rst_sticky", 32'(bus.done_sticky), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("lit_rst_no_done", 32'(done_cnt - d1), 32'd0);
    chk("lit_rst_ready",   32'(bus.cmd_ready),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
